dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single data-memory port between the core's Memory stage (master 0) and a secondary master (master 1: debug/DMA loader). It grants one load/store at a time using round-robin priority and tracks the single outstanding transaction. It routes the response back to the owning master and aborts with an error if memory never answers. It sits between the Memory stage and the data memory, on the same addr/addr_vld/wr_en/sel/wdata/rdata/d_valid protocol.

## Interface
- N, 32, data width
- ADDR_WIDTH, 32, address width
- TIMEOUT, 255, max wait cycles for i_mem_d_valid before error (1..255, 8-bit counter)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_mK_req  in  1  master K (K=0,1) request; held with payload until o_mK_gnt
- i_mK_we  in  1  1 = store, 0 = load
- i_mK_sel  in  4  byte enables
- i_mK_addr  in  ADDR_WIDTH  byte address
- i_mK_wdata  in  N  store data
- o_mK_gnt  out  1  request accepted this cycle
- o_mK_rvld  out  1  one-cycle response pulse (load data or store ack)
- o_mK_rdata  out  N  load data, valid with o_mK_rvld
- o_mK_err  out  1  timeout error, valid with o_mK_rvld
- o_mem_addr_vld  out  1  issue transaction to memory
- o_mem_wr_en  out  1  store
- o_mem_sel  out  4  byte enables
- o_mem_addr  out  ADDR_WIDTH  address
- o_mem_wdata  out  N  write data
- i_mem_rdata  in  N  read data
- i_mem_d_valid  in  1  memory response valid

## Operation
- FSM states: IDLE, WAIT.
- IDLE: if any i_mK_req is high, select the winner and drive the o_mem_* outputs combinationally from its payload with o_mem_addr_vld=1. Assert o_mK_gnt for the winner in the same cycle, latch owner, and go to WAIT.
- Round-robin: a single requester wins outright. When both request, the master not granted last wins. The last-grant register resets to 1, so master 0 wins the first tie.
- WAIT: o_mem_addr_vld=0 and no grants. A wait counter starts at 0 and increments each WAIT cycle.
- i_mem_d_valid in WAIT: register i_mem_rdata (stores: rdata=0) and route it to the owner. Go to IDLE.
- Counter reaching TIMEOUT without d_valid: owner gets rvld with err=1 and rdata=0. Go to IDLE.
- d_valid outside WAIT (late or stray) is ignored.
- When o_mem_addr_vld=0, o_mem_addr, o_mem_wdata, o_mem_sel and o_mem_wr_en are driven 0, never Z.
- A non-owner's o_mK_rvld stays 0, and its o_mK_rdata/o_mK_err hold 0.
- Request dropped by the master before grant: no effect, no state change.

## Timing
- Reset: state=IDLE, last-grant=1, counter=0. All outputs 0.
- Reset asserted mid-WAIT: transaction abandoned, no response is produced, outputs 0 immediately (async).
- Grant latency: 0 cycles, combinational in IDLE.
- Response latency: i_mem_d_valid at edge t leads to o_mK_rvld high for exactly the cycle after t.
- The FSM is in IDLE in that response cycle, so a new grant can occur in the same cycle as rvld. Back-to-back transactions are therefore spaced by memory latency + 1.
- Timeout: grant at cycle g, no d_valid, leads to rvld+err in cycle g+TIMEOUT+1.
- d_valid on the same cycle the counter hits TIMEOUT: data wins, err=0.
- Both requests held continuously: grants alternate 0,1,0,1…

## Test plan
- Single load, master 0: addr=0x100, sel=4'hF, memory replies rdata=0xDEADBEEF 2 cycles after grant -> m0_gnt same cycle, o_mem_addr=0x100, m0_rvld=1 with rdata=0xDEADBEEF, m1 outputs 0.
- Contention: both masters request continuously, 4 transactions at 1-cycle memory latency -> grants 0,1,0,1, each rvld to the correct owner, no grant while in WAIT.
- Store from master 1: we=1, wdata=0x12345678, sel=4'h3 -> o_mem_wr_en=1, o_mem_wdata=0x12345678, o_mem_sel=4'h3, m1_rvld ack with err=0.
- Timeout: TIMEOUT=4, memory never answers -> m0_rvld with err=1, rdata=0 four cycles after WAIT entry+1. A later stray d_valid produces no rvld.
- Reset mid-WAIT: assert rst_n=0 while waiting -> all outputs 0 asynchronously. After release, master 0 wins a tie and the stale d_valid is ignored.
- Edge race: d_valid arrives exactly at count=TIMEOUT -> rvld with err=0 and valid data.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side bundles for the data-memory arbiter.
interface dmem_req_if #(parameter int N = 32, parameter int ADDR_WIDTH = 32);
  logic req, we, gnt, rvld, err;
  logic [3:0] sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [N-1:0] wdata, rdata;
  modport master (output req, we, sel, addr, wdata, input gnt, rvld, rdata, err);
  modport slave (input req, we, sel, addr, wdata, output gnt, rvld, rdata, err);
endinterface

interface dmem_mem_if #(parameter int N = 32, parameter int ADDR_WIDTH = 32);
  logic addr_vld, wr_en, d_valid;
  logic [3:0] sel;
  logic [ADDR_WIDTH-1:0] addr;
  logic [N-1:0] wdata, rdata;
  modport master (output addr_vld, wr_en, sel, addr, wdata, input rdata, d_valid);
  modport slave (input addr_vld, wr_en, sel, addr, wdata, output rdata, d_valid);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-master arbiter for the single data-memory port.
// One transaction outstanding; the response is registered and routed to its owner.
module dmem_arbiter #(
  parameter int N = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  dmem_req_if.slave m0,
  dmem_req_if.slave m1,
  dmem_mem_if.master mem
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, own_q, own_d, we_q, we_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] rvld_q, rvld_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic win, issue, tout;
  always_comb begin
    win = (m0.req & m1.req) ? ~last_q : m1.req;
    issue = rst_n & (state_q == IDLE) & (m0.req | m1.req);
    // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the TIMEOUT-th one
    tout = cnt_q == 8'(TIMEOUT - 1);
    state_d = state_q;
    last_d = last_q;
    own_d = own_q;
    we_d = we_q;
    cnt_d = cnt_q;
    rvld_d = '0;
    rdata_d = '0;
    err_d = 1'b0;
    if (issue) begin
      state_d = WAIT;
      last_d = win;
      own_d = win;
      we_d = win ? m1.we : m0.we;
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 8'd1;
      if (mem.d_valid | tout) begin
        state_d = IDLE;
        rvld_d = own_q ? 2'b10 : 2'b01;
        rdata_d = (mem.d_valid & ~we_q) ? mem.rdata : '0;
        err_d = ~mem.d_valid;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      own_q <= 1'b0;
      we_q <= 1'b0;
      cnt_q <= '0;
      rvld_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      own_q <= own_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      rvld_q <= rvld_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  assign m0.gnt = issue & ~win;
  assign m1.gnt = issue & win;
  assign mem.addr_vld = issue;
  assign mem.wr_en = issue & (win ? m1.we : m0.we);
  assign mem.sel = issue ? (win ? m1.sel : m0.sel) : '0;
  assign mem.addr = issue ? (win ? m1.addr : m0.addr) : '0;
  assign mem.wdata = issue ? (win ? m1.wdata : m0.wdata) : '0;
  assign m0.rvld = rvld_q[0];
  assign m1.rvld = rvld_q[1];
  assign m0.rdata = rvld_q[0] ? rdata_q : '0;
  assign m1.rdata = rvld_q[1] ? rdata_q : '0;
  assign m0.err = rvld_q[0] & err_q;
  assign m1.err = rvld_q[1] & err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against a cycle-level transaction model of the arbiter.
module tb_dmem_arbiter;
  localparam int T = 4;
  logic clk = 1'b0;
  logic rst_n;
  dmem_req_if m0_if ();
  dmem_req_if m1_if ();
  dmem_mem_if mem_if ();
  dmem_arbiter #(.N(32), .ADDR_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .mem(mem_if)
  );
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int cyc, gcyc;
  bit busy, owner, ostore, last, er, w;
  bit [1:0] rv;
  logic [31:0] rd;
  logic [71:0] exp_a, got_a;
  logic [67:0] exp_b, got_b;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h expected=%h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy = 0; last = 1; rv = '0; rd = '0; er = 0; cyc = 0; gcyc = 0; owner = 0; ostore = 0;
  endtask

  function automatic bit winner();
    if (m0_if.req && m1_if.req) return !last;
    return m1_if.req;
  endfunction

  task automatic model_update();
    if (rst_n) begin
      rv = '0; rd = '0; er = 0;
      if (busy) begin
        if (mem_if.d_valid) begin
          rv[owner] = 1; rd = ostore ? 32'h0 : mem_if.rdata; busy = 0;
        end else if (cyc == gcyc + T) begin
          rv[owner] = 1; er = 1; busy = 0;
        end
      end else if (m0_if.req || m1_if.req) begin
        w = winner(); owner = w; last = w; busy = 1; gcyc = cyc;
        ostore = w ? m1_if.we : m0_if.we;
      end
      cyc++;
    end
  endtask

  task automatic compare();
    w = winner();
    exp_a = '0;
    if (rst_n && !busy && (m0_if.req || m1_if.req))
      exp_a = w ? {1'b0, 1'b1, 1'b1, m1_if.we, m1_if.sel, m1_if.addr, m1_if.wdata}
                : {1'b1, 1'b0, 1'b1, m0_if.we, m0_if.sel, m0_if.addr, m0_if.wdata};
    got_a = {m0_if.gnt, m1_if.gnt, mem_if.addr_vld, mem_if.wr_en, mem_if.sel, mem_if.addr, mem_if.wdata};
    exp_b = {rv[0], rv[0] ? rd : 32'h0, rv[0] & er, rv[1], rv[1] ? rd : 32'h0, rv[1] & er};
    got_b = {m0_if.rvld, m0_if.rdata, m0_if.err, m1_if.rvld, m1_if.rdata, m1_if.err};
    nvec++;
    if (got_a !== exp_a) begin
      nmis++;
      $display("FAIL model_issue got=%h expected=%h @%0t", got_a, exp_a, $time);
    end
    nvec++;
    if (got_b !== exp_b) begin
      nmis++;
      $display("FAIL model_resp got=%h expected=%h @%0t", got_b, exp_b, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set(input bit r0, input bit r1, input bit dv);
    m0_if.req = r0; m1_if.req = r1; mem_if.d_valid = dv;
  endtask

  initial begin
    rst_n = 0;
    model_reset();
    set(0, 0, 0);
    mem_if.rdata = '0;
    m0_if.we = 0; m0_if.sel = 4'hF; m0_if.addr = 32'h100; m0_if.wdata = 32'hAAAA5555;
    m1_if.we = 1; m1_if.sel = 4'h3; m1_if.addr = 32'h200; m1_if.wdata = 32'h12345678;
    #3;
    chk("reset_outputs", {m0_if.gnt, m1_if.gnt, mem_if.addr_vld, m0_if.rvld, m1_if.rvld}, 0);
    @(posedge clk); #1 rst_n = 1;
    // single load from master 0, memory answers two cycles after grant
    tick(); set(1, 0, 0); #2;
    chk("load_gnt0", {m0_if.gnt, m1_if.gnt, mem_if.addr_vld}, 3'b101);
    chk("load_addr", mem_if.addr, 32'h100);
    tick(); set(0, 0, 0); #2;
    chk("wait_idle_bus", {mem_if.addr_vld, mem_if.addr}, 0);
    tick(); set(0, 0, 1); mem_if.rdata = 32'hDEADBEEF;
    tick(); set(0, 0, 0); #2;
    chk("load_rvld", {m0_if.rvld, m1_if.rvld}, 2'b10);
    chk("load_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("load_m1_quiet", m1_if.rdata, 0);
    // store from master 1
    tick(); set(0, 1, 0); #2;
    chk("store_bus", {m1_if.gnt, mem_if.wr_en, mem_if.sel, mem_if.wdata}, {2'b11, 4'h3, 32'h12345678});
    tick(); set(0, 0, 1); mem_if.rdata = 32'hFFFFFFFF;
    tick(); set(0, 0, 0); #2;
    chk("store_ack", {m1_if.rvld, m1_if.err, m1_if.rdata}, {2'b10, 32'h0});
    // both requesting continuously, 1-cycle memory latency
    for (int i = 0; i < 8; i++) begin
      tick(); set(1, 1, i[0]); mem_if.rdata = 32'h100 + i; #2;
      if (i[0]) chk("rr_no_gnt_in_wait", {m0_if.gnt, m1_if.gnt, mem_if.addr_vld}, 0);
      else chk("rr_gnt", {m0_if.gnt, m1_if.gnt}, (i % 4 == 0) ? 2'b10 : 2'b01);
      if (!i[0] && i >= 2) chk("rr_rvld", {m0_if.rvld, m1_if.rvld}, ((i - 2) % 4 == 0) ? 2'b10 : 2'b01);
    end
    tick(); set(0, 0, 0); #2;
    chk("rr_last_rvld", {m0_if.rvld, m1_if.rvld, m1_if.rdata}, {2'b01, 32'h0});
    // timeout: no answer from memory
    tick(); set(1, 0, 0);
    repeat (3) begin tick(); set(0, 0, 0); end
    tick(); #2;
    chk("tout_not_early", m0_if.rvld, 0);
    tick(); #2;
    chk("tout_err", {m0_if.rvld, m0_if.err, m0_if.rdata}, {2'b11, 32'h0});
    tick(); set(0, 0, 1); mem_if.rdata = 32'h55;
    tick(); set(0, 0, 0); #2;
    chk("stray_dvalid", {m0_if.rvld, m1_if.rvld}, 0);
    // data arriving on the timeout cycle wins
    tick(); set(1, 0, 0);
    repeat (3) begin tick(); set(0, 0, 0); end
    tick(); set(0, 0, 1); mem_if.rdata = 32'hCAFEF00D;
    tick(); set(0, 0, 0); #2;
    chk("race_data_wins", {m0_if.rvld, m0_if.err, m0_if.rdata}, {2'b10, 32'hCAFEF00D});
    // reset while waiting; master 0 was granted last so only the reset makes it win the tie
    tick(); set(1, 0, 0);
    tick(); set(0, 0, 0); #2;
    rst_n = 0;
    model_reset();
    set(1, 1, 0); #1;
    chk("async_reset_out", {m0_if.gnt, m1_if.gnt, mem_if.addr_vld, mem_if.addr, m0_if.rvld, m1_if.rvld}, 0);
    tick(); tick();
    rst_n = 1;
    set(0, 0, 1); mem_if.rdata = 32'h99; #2;
    chk("post_reset_idle", mem_if.addr_vld, 0);
    tick(); set(0, 0, 0); #2;
    chk("stale_dvalid", {m0_if.rvld, m1_if.rvld}, 0);
    tick(); set(1, 1, 0); #2;
    chk("post_reset_tie", {m0_if.gnt, m1_if.gnt}, 2'b10);
    tick(); set(0, 1, 1); mem_if.rdata = 32'h77;
    tick(); set(0, 1, 0); #2;
    chk("resp_and_gnt", {m0_if.rvld, m0_if.rdata, m1_if.gnt}, {1'b1, 32'h77, 1'b1});
    tick(); set(0, 0, 1);
    tick(); set(0, 0, 0); #2;
    chk("final_store_ack", {m1_if.rvld, m1_if.err}, 2'b10);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
